button_conditioner: RTL
=======================

# button_conditioner

Conditions the raw push-button inputs of the brick-breaker board before the game core sees them. The block runs on the 50 MHz board clock and synchronises, debounces and edge-detects each button. It also auto-repeats the paddle-move buttons and holds every event pending until the game logic acknowledges it. It also owns the pause toggle, so the game core receives a clean level instead of a bouncing switch.

## Interface
- N_BTN, 5: number of button channels. Bit map: 0 stage_plus, 1 shoot, 2 pause, 3 plate_move_r, 4 plate_move_l.
- DEBOUNCE_CYCLES, 500000: consecutive stable cycles needed to accept a new level (10 ms at 50 MHz). Must be ≥ 2.
- REPEAT_DELAY, 25000000: cycles from press to the first auto-repeat (0.5 s).
- REPEAT_PERIOD, 6250000: cycles between later auto-repeats (8 Hz).
- REPEAT_MASK, 5'b11000: channels with auto-repeat enabled.
- PAUSE_BIT, 2: channel that drives pause_state.
- CLK  in  1  board clock; all flops update on its rising edge.
- RST  in  1  asynchronous, active-high reset.
- btn_raw  in  N_BTN  raw button levels, asynchronous to CLK; 1 = pressed.
- evt_ack  in  N_BTN  per-channel acknowledge from the consumer; level-sensitive.
- btn_level  out  N_BTN  debounced level.
- btn_press  out  N_BTN  one-cycle pulse on each debounced 0→1 transition.
- btn_event  out  N_BTN  one-cycle pulse on each press and each auto-repeat.
- evt_pending  out  N_BTN  sticky event flag; set by btn_event, cleared by evt_ack.
- pause_state  out  1  toggles on each press of channel PAUSE_BIT.

## Operation
- Synchroniser, per channel: two flops, s1 <= btn_raw, then s2 <= s1. Both reset to 0.
- Debounce counter, per channel:
  - Width is clog2(DEBOUNCE_CYCLES).
  - If s2 == btn_level, the counter resets to 0.
  - Otherwise, when the counter equals DEBOUNCE_CYCLES-1: btn_level <= s2 and the counter <= 0.
  - Otherwise the counter increments.
  - Any single-cycle return to agreement restarts the count.
- btn_press: registered, asserted in the same cycle btn_level first reads 1. Never asserted on release.
- Repeat FSM, one per channel set in REPEAT_MASK. States are IDLE, DELAY and REPEAT.
  - IDLE: on btn_press, go to DELAY and clear the repeat counter.
  - DELAY: the counter counts up. When it reaches REPEAT_DELAY-1, pulse btn_event, clear the counter and go to REPEAT.
  - REPEAT: when the counter reaches REPEAT_PERIOD-1, pulse btn_event and clear the counter.
  - btn_level = 0 in DELAY or REPEAT forces IDLE on the next edge, with no event. Release beats a coincident repeat pulse.
  - The repeat counter is sized for max(REPEAT_DELAY, REPEAT_PERIOD).
- btn_event: equals btn_press, OR'd with the repeat pulses on masked channels. On unmasked channels, btn_event equals btn_press.
- evt_pending[i], priority order:
  - btn_event[i] sets it.
  - else evt_ack[i] clears it.
  - else it holds.
  - Set wins over a simultaneous ack.
  - Events arriving while already pending are merged, not counted.
- pause_state: toggles in the cycle after btn_press[PAUSE_BIT]. Unaffected by acks.

## Timing
- Reset values: every output, synchroniser flop, counter and FSM is 0 / IDLE. RST asserted mid-count or mid-repeat aborts immediately. After RST falls, a button that is still held produces a fresh press following the normal latency.
- Press latency, measured from the first edge sampling the new btn_raw value (edge 0):
  - btn_level and btn_press assert after edge DEBOUNCE_CYCLES+1.
  - Release latency is identical.
- First repeat: REPEAT_DELAY cycles after btn_press. Later repeats: every REPEAT_PERIOD cycles.
- evt_pending rises one cycle after btn_event, because it is registered from btn_event. It falls on the edge where evt_ack is sampled high.
- pause_state changes one cycle after btn_press[PAUSE_BIT].
- Channels are fully independent. Simultaneous presses on several channels each produce their own pulses in the same cycle.

## Test plan
- Clean press, with DEBOUNCE_CYCLES=4: btn_raw[1] rises before edge 0 and holds 20 cycles.
  - Required: btn_level[1]=1 and a single btn_press[1] pulse after edge 5.
  - Required: evt_pending[1]=1 after edge 6.
  - Required: evt_ack[1] held 1 cycle clears it.
- Bounce: btn_raw[0] toggles 1,0,1,1,0,1,1,1,1,1 cycle by cycle. Required: exactly one btn_press[0], and btn_level[0] rises only after 4 consecutive stable-high samples at s2.
- Auto-repeat, with REPEAT_DELAY=10, REPEAT_PERIOD=3, DEBOUNCE_CYCLES=4: btn_raw[3] held for 30 cycles past btn_press.
  - Required: btn_event[3] at +0, +10, +13, +16, … relative to btn_press.
  - Required: no event after release.
  - Same stimulus on channel 1 (unmasked): exactly one btn_event.
- Pause: two separate clean presses of btn_raw[2]. Required: pause_state goes 0→1→0, each change one cycle after the corresponding btn_press[2].
- Ack collision: evt_ack[4] held high continuously while channel 4 repeats. Required: evt_pending[4] pulses high for exactly one cycle after each btn_event[4].
- Reset mid-operation: assert RST during the DELAY state with the button held, then release RST. Required: all outputs are 0 during reset, and btn_press reasserts 6 cycles after RST falls (DEBOUNCE_CYCLES=4).

Source files
------------

// File: rtl/button_conditioner.sv
// Push-button front end for the brick-breaker board: synchronise, debounce, edge-detect,
// auto-repeat the paddle buttons, hold events until acknowledged and own the pause toggle.
module button_conditioner #(
    parameter int               N_BTN           = 5,
    parameter int               DEBOUNCE_CYCLES = 500000,
    parameter int               REPEAT_DELAY    = 25000000,
    parameter int               REPEAT_PERIOD   = 6250000,
    parameter logic [N_BTN-1:0] REPEAT_MASK     = 5'b11000,
    parameter int               PAUSE_BIT       = 2
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [N_BTN-1:0] btn_raw,
    input  logic [N_BTN-1:0] evt_ack,
    output logic [N_BTN-1:0] btn_level,
    output logic [N_BTN-1:0] btn_press,
    output logic [N_BTN-1:0] btn_event,
    output logic [N_BTN-1:0] evt_pending,
    output logic             pause_state
);

    localparam int DB_W        = $clog2(DEBOUNCE_CYCLES);
    localparam int RPT_MAX_CYC = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int RPT_W       = (RPT_MAX_CYC > 1) ? $clog2(RPT_MAX_CYC) : 1;

    localparam logic [DB_W-1:0]  DB_MAX = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [RPT_W-1:0] RD_MAX = RPT_W'(REPEAT_DELAY - 1);
    localparam logic [RPT_W-1:0] RP_MAX = RPT_W'(REPEAT_PERIOD - 1);

    typedef enum logic [1:0] {
        RPT_IDLE,
        RPT_DELAY,
        RPT_REPEAT
    } rpt_state_e;

    logic [N_BTN-1:0] sync1_q;
    logic [N_BTN-1:0] sync2_q;
    logic [N_BTN-1:0] rpt_pulse;
    logic [N_BTN-1:0] pending_q;
    logic             pause_q;

    // NOTE: every flop is written with <= so all registers sample the pre-edge values together.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= btn_raw;
            sync2_q <= sync1_q;
        end
    end

    for (genvar i = 0; i < N_BTN; i++) begin : g_chan
        logic [DB_W-1:0] db_cnt_q;
        logic [DB_W-1:0] db_cnt_d;
        logic            level_q;
        logic            level_d;
        logic            press_q;
        logic            press_d;

        // Any cycle where the synchronised input agrees with the accepted level restarts the count.
        always_comb begin
            db_cnt_d = db_cnt_q;
            level_d  = level_q;
            press_d  = 1'b0;
            if (sync2_q[i] == level_q) begin
                db_cnt_d = '0;
            end else if (db_cnt_q == DB_MAX) begin
                db_cnt_d = '0;
                level_d  = sync2_q[i];
                press_d  = sync2_q[i];
            end else begin
                db_cnt_d = db_cnt_q + 1'b1;
            end
        end

        always_ff @(posedge CLK or posedge RST) begin
            if (RST) begin
                db_cnt_q <= '0;
                level_q  <= 1'b0;
                press_q  <= 1'b0;
            end else begin
                db_cnt_q <= db_cnt_d;
                level_q  <= level_d;
                press_q  <= press_d;
            end
        end

        if (REPEAT_MASK[i]) begin : g_rpt
            rpt_state_e     state_q;
            logic [RPT_W-1:0] rpt_cnt_q;

            always_ff @(posedge CLK or posedge RST) begin
                if (RST) begin
                    state_q   <= RPT_IDLE;
                    rpt_cnt_q <= '0;
                end else begin
                    case (state_q)
                        RPT_IDLE: begin
                            if (press_q) begin
                                state_q   <= RPT_DELAY;
                                rpt_cnt_q <= '0;
                            end
                        end
                        RPT_DELAY: begin
                            if (!level_q) begin
                                state_q <= RPT_IDLE;
                            end else if (rpt_cnt_q == RD_MAX) begin
                                state_q   <= RPT_REPEAT;
                                rpt_cnt_q <= '0;
                            end else begin
                                rpt_cnt_q <= rpt_cnt_q + 1'b1;
                            end
                        end
                        RPT_REPEAT: begin
                            if (!level_q) begin
                                state_q <= RPT_IDLE;
                            end else if (rpt_cnt_q == RP_MAX) begin
                                rpt_cnt_q <= '0;
                            end else begin
                                rpt_cnt_q <= rpt_cnt_q + 1'b1;
                            end
                        end
                        default: state_q <= RPT_IDLE;
                    endcase
                end
            end

            // Decoded from flops only; gating with level_q lets a release suppress a coincident repeat.
            assign rpt_pulse[i] = level_q &&
                                  (((state_q == RPT_DELAY)  && (rpt_cnt_q == RD_MAX)) ||
                                   ((state_q == RPT_REPEAT) && (rpt_cnt_q == RP_MAX)));
        end else begin : g_norpt
            assign rpt_pulse[i] = 1'b0;
        end

        assign btn_level[i] = level_q;
        assign btn_press[i] = press_q;
    end

    assign btn_event = btn_press | rpt_pulse;

    // A new event wins over a simultaneous acknowledge; repeated events merge into one flag.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            pending_q <= '0;
            pause_q   <= 1'b0;
        end else begin
            pending_q <= btn_event | (pending_q & ~evt_ack);
            if (btn_press[PAUSE_BIT]) begin
                pause_q <= ~pause_q;
            end
        end
    end

    assign evt_pending = pending_q;
    assign pause_state = pause_q;

endmodule
